// File: rtl/csa_add_sequencer_pkg.sv
// Shared types and constants for the byte-serial carry-skip add sequencer.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    localparam int ID_W           = 1;
    localparam int NBYTES_DEFAULT = 4;

endpackage

// File: rtl/csa_add_sequencer_slice8.sv
// Combinational 8-bit carry-skip adder: two 4-bit ripple blocks, each bypassed
// when all of its bits propagate. Also exposes the carry into bit 7.
module csa_slice8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       c7in
);

    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] c;
    logic       blk0_cout;

    always_comb begin
        p = a ^ b;
        g = a & b;
        c = '0;
        c[0] = cin;
        for (int i = 1; i < 4; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        // a fully-propagating block passes its carry-in straight through
        blk0_cout = (&p[3:0]) ? cin : (g[3] | (p[3] & c[3]));
        c[4] = blk0_cout;
        for (int i = 5; i < 8; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        cout = (&p[7:4]) ? blk0_cout : (g[7] | (p[7] & c[7]));
        sum  = p ^ c;
        c7in = c[7];
    end

endmodule

// File: rtl/csa_add_sequencer.sv
// Round-robin arbitrated multi-byte adder: one shared 8-bit carry-skip slice
// processes the operands LSB byte first, one byte per clock.
module csa_add_sequencer
    import csa_pkg::*;
#(
    parameter  int NBYTES = NBYTES_DEFAULT,
    localparam int W      = 8 * NBYTES,
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf,
    output logic         rsp_id,
    output logic         busy
);

    csa_state_e state;
    csa_state_e state_nxt;

    logic [IDX_W-1:0]       idx;
    logic [NBYTES-1:0][7:0] a_q;
    logic [NBYTES-1:0][7:0] b_q;
    logic [NBYTES-1:0][7:0] sum_q;
    logic                   carry_q;
    logic                   cout_q;
    logic                   ovf_q;
    logic [ID_W-1:0]        id_q;
    logic                   last_grant;

    logic grant_any;
    logic grant_id;
    logic accept;
    logic last_step;

    logic [7:0] slice_a;
    logic [7:0] slice_b;
    logic [7:0] slice_sum;
    logic       slice_cout;
    logic       slice_c7in;

    function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign last_step = (idx == IDX_W'(NBYTES - 1));

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && rst_n) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    accept     = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shared slice: always fed with the current byte of the captured operands.
    assign slice_a = a_q[idx];
    assign slice_b = b_q[idx];

    csa_slice8 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c7in (slice_c7in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            id_q       <= '0;
            last_grant <= 1'b1;
            sum_q      <= '0;
        end else if (accept) begin
            idx        <= '0;
            carry_q    <= grant_id ? req1_cin : req0_cin;
            id_q       <= grant_id;
            last_grant <= grant_id;
        end else if (state == RUN) begin
            sum_q[idx] <= slice_sum;
            carry_q    <= slice_cout;
            idx        <= last_step ? '0 : idx + IDX_W'(1);
            if (last_step) begin
                cout_q <= slice_cout;
                ovf_q  <= signed_ovf(slice_c7in, slice_cout);
            end
        end
    end

    // Operands are pure data, sampled only on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= grant_id ? req1_a : req0_a;
            b_q <= grant_id ? req1_b : req0_b;
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_id    = id_q;

endmodule
